// File: rtl/dsram_arbiter.sv
// dsram_arbiter: shares one SRAM-like data port between the two memory lanes
// of the dual-issue core.
//   lane 0 (older slot) has fixed priority over lane 1.
//   A request that stalls on addr_ok is frozen in a hold register until it
//   is accepted.
//   Accepted requests are tracked in issue order so each response is routed
//   back to the lane that issued it.
//   A flush marks every not-yet-returned request so that its response is
//   dropped.
// Ports:
//   clk, resetn                         clock, async active-low reset
//   rN_req/wr/size/wstrb/addr/wdata     lane N request (N = 0, 1)
//   rN_addr_ok, rN_data_ok, rN_rdata    lane N handshakes / read data
//   flush                               single-cycle exception/eret flush
//   data_sram_*                         shared port towards cache/AXI bridge
//   busy                                a request is held or in flight

// Per-lane handshake/response router.
module dsram_arbiter_lane #(
  parameter int LANE = 0
) (
  input  logic        acc,          // accepted request reports addr_ok
  input  logic        acc_lane,
  input  logic        head_vld,     // order queue non-empty
  input  logic        head_lane,
  input  logic        head_disc,
  input  logic        flush,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        [31:0] rdata
);
  logic is_head;

  assign is_head = head_vld & (head_lane == 1'(LANE));
  assign addr_ok = acc & (acc_lane == 1'(LANE));
  // A response arriving in the flush cycle belongs to a killed request too.
  assign data_ok = is_head & sram_data_ok & ~head_disc & ~flush;
  assign rdata   = is_head ? sram_rdata : 32'h0;
endmodule

module dsram_arbiter #(
  parameter int MAX_OS = 2          // 1..4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        r0_req,
  input  logic        r0_wr,
  input  logic [1:0]  r0_size,
  input  logic [3:0]  r0_wstrb,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_addr_ok,
  output logic        r0_data_ok,
  output logic [31:0] r0_rdata,

  input  logic        r1_req,
  input  logic        r1_wr,
  input  logic [1:0]  r1_size,
  input  logic [3:0]  r1_wstrb,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_addr_ok,
  output logic        r1_data_ok,
  output logic [31:0] r1_rdata,

  input  logic        flush,

  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,

  output logic        busy
);
  localparam int NUM_LANES = 2;

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state_q, state_d;

  req_t [NUM_LANES-1:0] lane_req;
  req_t port;
  req_t hold_q;
  logic hold_lane_q, hold_kill_q;

  // Order queue: one {lane, discard} entry per accepted request.
  logic [3:0] q_lane, q_disc;
  logic [1:0] head_q, tail_q;
  logic [2:0] count_q;

  logic sel, full, pop;
  logic sram_req, push, push_disc, acc, acc_lane, capture, kill_set;

  assign lane_req[0] = {r0_wr, r0_size, r0_wstrb, r0_addr, r0_wdata};
  assign lane_req[1] = {r1_wr, r1_size, r1_wstrb, r1_addr, r1_wdata};

  assign sel  = ~r0_req;                      // older lane first
  assign full = (count_q == 3'(MAX_OS));
  assign pop  = data_sram_data_ok & (count_q != 3'd0);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OS - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    sram_req  = 1'b0;
    port      = lane_req[sel];
    acc_lane  = sel;
    acc       = 1'b0;
    push      = 1'b0;
    push_disc = 1'b0;
    capture   = 1'b0;
    kill_set  = 1'b0;
    case (state_q)
      IDLE: begin
        // resetn gate keeps the pass-through quiet while reset is held.
        sram_req = (r0_req | r1_req) & ~full & ~flush & resetn;
        if (sram_req & data_sram_addr_ok) begin
          push = 1'b1;
          acc  = 1'b1;
        end else if (sram_req) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Never withdrawn or switched once presented to the port.
        sram_req = 1'b1;
        port     = hold_q;
        acc_lane = hold_lane_q;
        if (data_sram_addr_ok) begin
          push      = 1'b1;
          push_disc = hold_kill_q | flush;
          acc       = ~(hold_kill_q | flush);
          state_d   = IDLE;
        end else if (flush) begin
          kill_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q      <= '0;
      hold_lane_q <= 1'b0;
      hold_kill_q <= 1'b0;
      q_lane      <= '0;
      q_disc      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      if (capture) begin
        hold_q      <= lane_req[sel];
        hold_lane_q <= sel;
        hold_kill_q <= 1'b0;
      end else if (kill_set) begin
        hold_kill_q <= 1'b1;
      end
      // Marking unused slots too is harmless: a push rewrites its bit.
      if (flush) q_disc <= '1;
      if (push) begin
        q_lane[tail_q] <= acc_lane;
        q_disc[tail_q] <= push_disc;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic [NUM_LANES-1:0]       addr_ok_v, data_ok_v;
  logic [NUM_LANES-1:0][31:0] rdata_v;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dsram_arbiter_lane #(.LANE(i)) u_lane (
      .acc          (acc),
      .acc_lane     (acc_lane),
      .head_vld     (count_q != 3'd0),
      .head_lane    (q_lane[head_q]),
      .head_disc    (q_disc[head_q]),
      .flush        (flush),
      .sram_data_ok (data_sram_data_ok),
      .sram_rdata   (data_sram_rdata),
      .addr_ok      (addr_ok_v[i]),
      .data_ok      (data_ok_v[i]),
      .rdata        (rdata_v[i])
    );
  end

  assign r0_addr_ok = addr_ok_v[0];
  assign r1_addr_ok = addr_ok_v[1];
  assign r0_data_ok = data_ok_v[0];
  assign r1_data_ok = data_ok_v[1];
  assign r0_rdata   = rdata_v[0];
  assign r1_rdata   = rdata_v[1];

  assign data_sram_req   = sram_req;
  assign data_sram_wr    = port.wr;
  assign data_sram_size  = port.size;
  assign data_sram_wstrb = port.wstrb;
  assign data_sram_addr  = port.addr;
  assign data_sram_wdata = port.wdata;

  assign busy = (state_q == HOLD) | (count_q != 3'd0);
endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: a vector table for the basic ordering/flush
// cases, hand sequences for hold/full/kill/reset, then random traffic
// checked against a queue-based model of the arbitration rules.
module tb_dsram_arbiter;
  localparam int MAX_OS = 2;

  logic clk = 1'b0;
  logic resetn;
  logic r0_req, r0_wr, r1_req, r1_wr;
  logic [1:0]  r0_size, r1_size;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic r0_addr_ok, r0_data_ok, r1_addr_ok, r1_data_ok;
  logic [31:0] r0_rdata, r1_rdata;
  logic flush;
  logic data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic data_sram_addr_ok, data_sram_data_ok;
  logic busy;

  dsram_arbiter #(.MAX_OS(MAX_OS)) dut (
    .clk(clk), .resetn(resetn),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_size(r0_size), .r0_wstrb(r0_wstrb),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_addr_ok(r0_addr_ok),
    .r0_data_ok(r0_data_ok), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_size(r1_size), .r1_wstrb(r1_wstrb),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_addr_ok(r1_addr_ok),
    .r1_data_ok(r1_data_ok), .r1_rdata(r1_rdata),
    .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { bit lane; bit disc; } ent_t;
  ent_t mq[$];                  // accepted, not yet answered, in order
  bit          mh_vld, mh_lane, mh_kill;
  logic [70:0] mh_fields;       // {wr, size, wstrb, addr, wdata}

  bit          e_req, e_acc, e_lane, e_busy;
  logic [70:0] e_fields;
  logic [1:0]  e_ao, e_do;
  logic [31:0] e_rd0, e_rd1;

  function automatic logic [70:0] lane_fields(input bit n);
    return n ? {r1_wr, r1_size, r1_wstrb, r1_addr, r1_wdata}
             : {r0_wr, r0_size, r0_wstrb, r0_addr, r0_wdata};
  endfunction

  task automatic model_reset();
    mq.delete();
    mh_vld = 0; mh_lane = 0; mh_kill = 0; mh_fields = '0;
  endtask

  task automatic model_eval();
    e_ao = '0; e_do = '0; e_rd0 = '0; e_rd1 = '0;
    if (mh_vld) begin
      e_req = 1; e_lane = mh_lane; e_fields = mh_fields;
    end else begin
      e_lane   = !r0_req;
      e_fields = lane_fields(e_lane);
      e_req    = (r0_req || r1_req) && (mq.size() < MAX_OS) && !flush;
    end
    e_acc = e_req && data_sram_addr_ok;
    if (e_acc && !(mh_vld && (mh_kill || flush))) e_ao[e_lane] = 1'b1;
    if (mq.size() > 0) begin
      if (mq[0].lane) e_rd1 = data_sram_rdata;
      else            e_rd0 = data_sram_rdata;
      if (data_sram_data_ok && !mq[0].disc && !flush) e_do[mq[0].lane] = 1'b1;
    end
    e_busy = mh_vld || (mq.size() > 0);
  endtask

  task automatic model_update();
    ent_t n;
    if (data_sram_data_ok && mq.size() > 0) void'(mq.pop_front());
    if (flush) foreach (mq[i]) mq[i].disc = 1'b1;
    if (e_acc) begin
      n.lane = e_lane;
      n.disc = mh_vld && (mh_kill || flush);
      mq.push_back(n);
    end
    if (mh_vld) begin
      if (e_acc)      mh_vld  = 0;
      else if (flush) mh_kill = 1;
    end else if (e_req && !data_sram_addr_ok) begin
      mh_vld = 1; mh_lane = e_lane; mh_fields = e_fields; mh_kill = 0;
    end
  endtask

  task automatic check_model(input string tag);
    model_eval();
    chk({tag, ".hs"},
        {26'b0, data_sram_req, r0_addr_ok, r1_addr_ok, r0_data_ok, r1_data_ok, busy},
        {26'b0, e_req, e_ao[0], e_ao[1], e_do[0], e_do[1], e_busy});
    if (e_req) begin
      chk({tag, ".addr"}, data_sram_addr, e_fields[63:32]);
      chk({tag, ".wdata"}, data_sram_wdata, e_fields[31:0]);
      chk({tag, ".ctl"}, {25'b0, data_sram_wr, data_sram_size, data_sram_wstrb},
          {25'b0, e_fields[70:64]});
    end
    chk({tag, ".rd0"}, r0_rdata, e_rd0);
    chk({tag, ".rd1"}, r1_rdata, e_rd1);
  endtask

  // Inputs are set at the falling edge; outputs are sampled 1 unit later.
  task automatic settle(input string tag, input bit use_model);
    #1;
    if (use_model) check_model(tag);
    else           model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input bit a0, input bit a1, input bit aok, input bit dok,
                       input bit fl, input logic [31:0] srd);
    r0_req = a0; r1_req = a1; data_sram_addr_ok = aok;
    data_sram_data_ok = dok; flush = fl; data_sram_rdata = srd;
  endtask

  task automatic clear_inputs();
    drive(0, 0, 0, 0, 0, 32'h0);
    r0_wr = 0; r0_size = 2'd2; r0_wstrb = 4'hf; r0_addr = 32'h100; r0_wdata = 32'h0;
    r1_wr = 0; r1_size = 2'd2; r1_wstrb = 4'hf; r1_addr = 32'h200; r1_wdata = 32'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    r0_req = 1; r1_req = 1; data_sram_data_ok = 1;   // must all be masked
    model_reset();
    #1;
    chk("reset.hs", {26'b0, data_sram_req, r0_addr_ok, r1_addr_ok, r0_data_ok, r1_data_ok, busy}, 32'h0);
    chk("reset.rd0", r0_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r0, r1, aok, dok, fl;
    logic [31:0] srd;
    bit x_req;
    logic [31:0] x_addr;
    bit x_ao0, x_ao1, x_do0, x_do1;
    logic [31:0] x_rd0, x_rd1;
    bit x_busy;
  } vec_t;

  vec_t vt[16];

  task automatic fill_table();
    //           r0 r1 aok dok fl srd           req addr    ao0 ao1 do0 do1 rd0           rd1           busy
    vt[0]  = '{1, 1, 1, 0, 0, 32'h0,        1, 32'h100, 1, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[1]  = '{0, 1, 1, 0, 0, 32'h0,        1, 32'h200, 0, 1, 0, 0, 32'h0,        32'h0,        1};
    vt[2]  = '{0, 0, 0, 1, 0, 32'hAAAA0000, 0, 32'h0,   0, 0, 1, 0, 32'hAAAA0000, 32'h0,        1};
    vt[3]  = '{0, 0, 0, 1, 0, 32'h5555FFFF, 0, 32'h0,   0, 0, 0, 1, 32'h0,        32'h5555FFFF, 1};
    vt[4]  = '{0, 0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[5]  = '{1, 0, 1, 0, 0, 32'h0,        1, 32'h100, 1, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[6]  = '{0, 1, 1, 0, 0, 32'h0,        1, 32'h200, 0, 1, 0, 0, 32'h0,        32'h0,        1};
    vt[7]  = '{0, 0, 0, 0, 1, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        1};
    vt[8]  = '{0, 0, 0, 1, 0, 32'h12345678, 0, 32'h0,   0, 0, 0, 0, 32'h12345678, 32'h0,        1};
    vt[9]  = '{0, 0, 0, 1, 0, 32'h87654321, 0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h87654321, 1};
    vt[10] = '{0, 0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[11] = '{0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[12] = '{0, 0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[13] = '{1, 0, 1, 0, 0, 32'h0,        1, 32'h100, 1, 0, 0, 0, 32'h0,        32'h0,        0};
    vt[14] = '{0, 1, 1, 1, 1, 32'hCAFE0001, 0, 32'h0,   0, 0, 0, 0, 32'hCAFE0001, 32'h0,        1};
    vt[15] = '{0, 0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        0};
  endtask

  int n_ao1;
  bit [1:0] pend;

  initial begin
    resetn = 1'b1;
    clear_inputs();
    #2;
    do_reset();

    // ---- table ----
    fill_table();
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].r0, vt[i].r1, vt[i].aok, vt[i].dok, vt[i].fl, vt[i].srd);
      settle("vec", 0);
      chk($sformatf("vec%0d.hs", i),
          {26'b0, data_sram_req, r0_addr_ok, r1_addr_ok, r0_data_ok, r1_data_ok, busy},
          {26'b0, vt[i].x_req, vt[i].x_ao0, vt[i].x_ao1, vt[i].x_do0, vt[i].x_do1, vt[i].x_busy});
      if (vt[i].x_req) chk($sformatf("vec%0d.addr", i), data_sram_addr, vt[i].x_addr);
      chk($sformatf("vec%0d.rd0", i), r0_rdata, vt[i].x_rd0);
      chk($sformatf("vec%0d.rd1", i), r1_rdata, vt[i].x_rd1);
      advance();
    end

    // ---- hold stability: lane 1 stalls, lane 0 arrives during hold ----
    do_reset();
    r1_addr = 32'h1000; r0_addr = 32'h2000; n_ao1 = 0;
    for (int c = 0; c < 4; c++) begin
      drive(c > 0, 1, c == 3, 0, 0, 32'h0);
      settle("hold", 1);
      chk("hold.addr", data_sram_addr, 32'h1000);
      chk("hold.ao0", {31'b0, r0_addr_ok}, 32'h0);
      n_ao1 += int'(r1_addr_ok);
      advance();
    end
    chk("hold.ao1_count", n_ao1, 1);
    drive(1, 0, 1, 0, 0, 32'h0);
    settle("hold_next", 1);
    chk("hold_next.ao0", {31'b0, r0_addr_ok}, 32'h1);
    chk("hold_next.addr", data_sram_addr, 32'h2000);
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 1, 0, 32'h11110000 + c);
      settle("hold_drain", 1);
      advance();
    end

    // ---- full: third lane-0 request waits for a data_ok ----
    do_reset();
    for (int c = 0; c < 9; c++) begin
      r0_addr = 32'h3000 + 32'(4 * (c < 2 ? c : 2));
      drive(c < 6 && !(c == 5 && 0), 0, 1, c == 4 || c >= 6, 0, 32'h0);
      if (c == 5) drive(1, 0, 1, 0, 0, 32'h0);
      if (c >= 6) drive(0, 0, 0, c < 8, 0, 32'h0);
      settle("full", 1);
      if (c == 2 || c == 3 || c == 4) chk($sformatf("full%0d.req", c), {31'b0, data_sram_req}, 32'h0);
      if (c == 5) chk("full5.acc", {30'b0, data_sram_req, r0_addr_ok}, 32'h3);
      if (c <= 7) chk($sformatf("full%0d.busy", c), {31'b0, busy}, {31'b0, c != 0});
      if (c == 8) chk("full8.busy", {31'b0, busy}, 32'h0);
      advance();
    end

    // ---- flush during hold kills the held request ----
    do_reset();
    r0_addr = 32'h4000;
    drive(1, 0, 0, 0, 0, 32'h0); settle("kill0", 1); advance();
    drive(0, 0, 0, 0, 1, 32'h0); settle("kill1", 1); advance();
    drive(0, 0, 1, 0, 0, 32'h0); settle("kill2", 1);
    chk("kill2.req_ao0", {30'b0, data_sram_req, r0_addr_ok}, 32'h2);
    advance();
    drive(0, 0, 0, 1, 0, 32'h99); settle("kill3", 1);
    chk("kill3.do0", {31'b0, r0_data_ok}, 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 32'h0); settle("kill4", 1);
    chk("kill4.busy", {31'b0, busy}, 32'h0);
    advance();

    // ---- stray data_ok, then reset in the middle of a hold ----
    do_reset();
    drive(0, 0, 0, 1, 0, 32'h77); settle("stray", 1);
    chk("stray.out", {28'b0, r0_data_ok, r1_data_ok, busy, data_sram_req}, 32'h0);
    advance();
    drive(1, 0, 0, 0, 0, 32'h0); settle("rsthold0", 1); advance();
    #2;
    resetn = 1'b0;
    #1;
    chk("rsthold.req", {30'b0, data_sram_req, busy}, 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    r1_addr = 32'h5000;
    drive(0, 1, 1, 0, 0, 32'h0); settle("rsthold1", 1);
    chk("rsthold1.ao1", {31'b0, r1_addr_ok}, 32'h1);
    advance();
    drive(0, 0, 0, 1, 0, 32'h5); settle("rsthold2", 1); advance();

    // ---- random traffic against the model ----
    do_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 2; l++) begin
        if (!pend[l] && $urandom_range(1, 0) == 1) begin
          pend[l] = 1'b1;
          if (l == 0) begin
            r0_wr = 1'($urandom); r0_size = 2'($urandom); r0_wstrb = 4'($urandom);
            r0_addr = $urandom; r0_wdata = $urandom;
          end else begin
            r1_wr = 1'($urandom); r1_size = 2'($urandom); r1_wstrb = 4'($urandom);
            r1_addr = $urandom; r1_wdata = $urandom;
          end
        end
      end
      drive(pend[0], pend[1], $urandom_range(4, 0) < 3, $urandom_range(4, 0) < 2,
            $urandom_range(19, 0) == 0, $urandom);
      settle("rnd", 1);
      advance();
      for (int l = 0; l < 2; l++)
        if (e_ao[l] || flush) pend[l] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
